// File: rtl/if_fetch_pkg.sv
// Shared widths, state encoding and byte-assembly helper for the instruction fetch stage.
package if_fetch_pkg;

    localparam int          INST_ADDR_W = 32;
    localparam int          INST_W      = 32;
    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        READY = 2'd3
    } fetch_state_e;

    // Little-endian placement of one byte into the instruction word.
    function automatic logic [INST_W-1:0] insert_byte(
        input logic [INST_W-1:0] word,
        input logic [1:0]        idx,
        input logic [7:0]        data
    );
        logic [INST_W-1:0] r;
        r = word;
        r[{idx, 3'b000} +: 8] = data;
        return r;
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles a 32-bit instruction from four byte reads
// on a req/ack memory port and presents it to the IF/ID register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [5:0]             stall,
    input  logic                   ex_b_flag,
    input  logic [INST_ADDR_W-1:0] ex_b_target,
    input  logic                   id_b_flag,
    input  logic [INST_ADDR_W-1:0] id_b_target,
    output logic                   mem_req,
    output logic [INST_ADDR_W-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [7:0]             mem_rdata,
    output logic [INST_ADDR_W-1:0] if_pc,
    output logic [INST_W-1:0]      if_inst,
    output logic                   stallreq_if
);

    fetch_state_e           state_q, state_d;
    logic [INST_ADDR_W-1:0] pc_q, pc_d;
    logic [1:0]             cnt_q, cnt_d;
    logic [INST_W-1:0]      buf_q, buf_d;
    logic [INST_ADDR_W-1:0] tgt_lat_q, tgt_lat_d;
    logic                   mem_req_q, mem_req_d;
    logic [INST_ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [INST_ADDR_W-1:0] if_pc_q, if_pc_d;
    logic [INST_W-1:0]      if_inst_q, if_inst_d;
    logic                   stallreq_q, stallreq_d;

    logic                   redirect;
    logic [INST_ADDR_W-1:0] tgt;
    logic                   unused_stall_bits;

    // Only bit 0 of the stall vector belongs to this stage.
    assign unused_stall_bits = ^stall[5:1];

    assign redirect = ex_b_flag | id_b_flag;
    assign tgt      = ex_b_flag ? ex_b_target : id_b_target;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        tgt_lat_d = tgt_lat_q;

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                cnt_d   = 2'd0;
            end
            FETCH: begin
                if (redirect) begin
                    if (mem_ack) begin
                        pc_d  = tgt;
                        cnt_d = 2'd0;
                    end else begin
                        // The outstanding request must still complete before refetching.
                        tgt_lat_d = tgt;
                        state_d   = DRAIN;
                    end
                end else if (mem_ack) begin
                    buf_d = insert_byte(buf_q, cnt_q, mem_rdata);
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = READY;
                    end
                end
            end
            DRAIN: begin
                if (redirect) begin
                    tgt_lat_d = tgt;
                end
                if (mem_ack) begin
                    pc_d    = tgt_lat_d;
                    cnt_d   = 2'd0;
                    state_d = FETCH;
                end
            end
            READY: begin
                if (redirect) begin
                    pc_d    = tgt;
                    cnt_d   = 2'd0;
                    state_d = FETCH;
                end else if (!stall[0]) begin
                    pc_d    = pc_q + 32'd4;
                    cnt_d   = 2'd0;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered images of the next state.
        mem_req_d  = (state_d == FETCH) || (state_d == DRAIN);
        mem_addr_d = mem_addr_q;
        if (state_d == FETCH) begin
            mem_addr_d = pc_d + {30'd0, cnt_d};
        end
        if_pc_d    = (state_d == READY) ? pc_d  : ZERO_WORD;
        if_inst_d  = (state_d == READY) ? buf_d : ZERO_WORD;
        stallreq_d = (state_d != READY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= 2'd0;
            buf_q      <= ZERO_WORD;
            tgt_lat_q  <= ZERO_WORD;
            mem_req_q  <= 1'b0;
            mem_addr_q <= ZERO_WORD;
            if_pc_q    <= ZERO_WORD;
            if_inst_q  <= ZERO_WORD;
            stallreq_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            tgt_lat_q  <= tgt_lat_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            stallreq_q <= stallreq_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign if_pc       = if_pc_q;
    assign if_inst     = if_inst_q;
    assign stallreq_if = stallreq_q;

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: a byte memory model answers requests, queues hold
// expected addresses and presented instructions.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        ex_b_flag;
    logic [31:0] ex_b_target;
    logic        id_b_flag;
    logic [31:0] id_b_target;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        stallreq_if;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  mem [0:1023];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_inst_q[$];
    logic [31:0] exp_pc_q[$];

    if_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .ex_b_flag  (ex_b_flag),
        .ex_b_target(ex_b_target),
        .id_b_flag  (id_b_flag),
        .id_b_target(id_b_target),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .if_pc      (if_pc),
        .if_inst    (if_inst),
        .stallreq_if(stallreq_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] a1, a2, a3;
        a1 = a + 32'd1;
        a2 = a + 32'd2;
        a3 = a + 32'd3;
        return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a[9:0]]};
    endfunction

    function automatic void push_fetch(input logic [31:0] base);
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(base + 32'(k));
        exp_inst_q.push_back(word_at(base));
        exp_pc_q.push_back(base);
    endfunction

    task automatic tick();
        mem_rdata = mem[mem_addr[9:0]];
        @(posedge clk);
        #1;
        mem_rdata = mem[mem_addr[9:0]];
    endtask

    task automatic run_until_ready(output int cycles);
        cycles  = -1;
        mem_ack = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (stallreq_if === 1'b0) begin
                cycles = i;
                break;
            end
        end
        mem_ack = 1'b0;
    endtask

    // Scoreboard: every accepted request and every newly presented instruction.
    logic        prev_rdy = 1'b0;
    logic        rdy_now;
    logic [31:0] mon_e;
    always @(negedge clk) begin
        if (rst === 1'b1 && mem_req === 1'b1 && mem_ack === 1'b1) begin
            n_cmp++;
            if (exp_addr_q.size() == 0) begin
                n_err++;
                $display("FAIL ack_addr: got %h, none expected", mem_addr);
            end else begin
                mon_e = exp_addr_q.pop_front();
                if (mem_addr !== mon_e) begin
                    n_err++;
                    $display("FAIL ack_addr: got %h expected %h", mem_addr, mon_e);
                end
            end
        end
        rdy_now = (rst === 1'b1) && (stallreq_if === 1'b0);
        if (rdy_now && !prev_rdy) begin
            n_cmp += 2;
            if (exp_inst_q.size() == 0 || exp_pc_q.size() == 0) begin
                n_err++;
                $display("FAIL ready_inst: got inst %h pc %h, none expected", if_inst, if_pc);
            end else begin
                mon_e = exp_inst_q.pop_front();
                if (if_inst !== mon_e) begin
                    n_err++;
                    $display("FAIL ready_inst: got %h expected %h", if_inst, mon_e);
                end
                mon_e = exp_pc_q.pop_front();
                if (if_pc !== mon_e) begin
                    n_err++;
                    $display("FAIL ready_pc: got %h expected %h", if_pc, mon_e);
                end
            end
        end
        prev_rdy = rdy_now;
    end

    task automatic test_reset();
        rst = 1'b1;
        #3 rst = 1'b0;
        tick();
        tick();
        n_cmp += 5;
        if (mem_req !== 1'b0)      begin n_err++; $display("FAIL rst_req: got %b expected 0", mem_req); end
        if (mem_addr !== 32'h0)    begin n_err++; $display("FAIL rst_addr: got %h expected 0", mem_addr); end
        if (if_pc !== 32'h0)       begin n_err++; $display("FAIL rst_pc: got %h expected 0", if_pc); end
        if (if_inst !== 32'h0)     begin n_err++; $display("FAIL rst_inst: got %h expected 0", if_inst); end
        if (stallreq_if !== 1'b1)  begin n_err++; $display("FAIL rst_stallreq: got %b expected 1", stallreq_if); end
        rst = 1'b1;
    endtask

    task automatic test_first_fetch();
        int cyc;
        exp_addr_q.push_back(32'd0); exp_addr_q.push_back(32'd1);
        exp_addr_q.push_back(32'd2); exp_addr_q.push_back(32'd3);
        exp_inst_q.push_back(32'h0050_0013);
        exp_pc_q.push_back(32'h0);
        run_until_ready(cyc);
        stall = 6'b000001;
        n_cmp++;
        if (cyc !== 5) begin n_err++; $display("FAIL first_latency: got %0d expected 5", cyc); end
    endtask

    task automatic test_stall_hold();
        int cyc;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp += 4;
            if (if_inst !== 32'h0050_0013) begin n_err++; $display("FAIL stall_inst: got %h expected 00500013", if_inst); end
            if (if_pc !== 32'h0)           begin n_err++; $display("FAIL stall_pc: got %h expected 0", if_pc); end
            if (mem_req !== 1'b0)          begin n_err++; $display("FAIL stall_req: got %b expected 0", mem_req); end
            if (stallreq_if !== 1'b0)      begin n_err++; $display("FAIL stall_stallreq: got %b expected 0", stallreq_if); end
        end
        push_fetch(32'd4);
        stall = 6'b000000;
        tick();
        n_cmp += 2;
        if (mem_addr !== 32'd4) begin n_err++; $display("FAIL release_addr: got %h expected 4", mem_addr); end
        if (mem_req !== 1'b1)   begin n_err++; $display("FAIL release_req: got %b expected 1", mem_req); end
        run_until_ready(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL fetch_latency: got %0d expected 4", cyc); end
    endtask

    task automatic test_drain_ex();
        int cyc;
        tick();
        exp_addr_q.push_back(32'h8); exp_addr_q.push_back(32'h9);
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        ex_b_flag = 1'b1; ex_b_target = 32'h40;
        tick();
        ex_b_flag = 1'b0;
        n_cmp += 3;
        if (mem_addr !== 32'hA)   begin n_err++; $display("FAIL drain_addr: got %h expected 0000000a", mem_addr); end
        if (mem_req !== 1'b1)     begin n_err++; $display("FAIL drain_req: got %b expected 1", mem_req); end
        if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL drain_stallreq: got %b expected 1", stallreq_if); end
        tick();
        n_cmp++;
        if (mem_addr !== 32'hA) begin n_err++; $display("FAIL drain_hold: got %h expected 0000000a", mem_addr); end
        exp_addr_q.push_back(32'hA);
        push_fetch(32'h40);
        mem_ack = 1'b1;
        tick();
        n_cmp++;
        if (mem_addr !== 32'h40) begin n_err++; $display("FAIL drain_exit_addr: got %h expected 00000040", mem_addr); end
        run_until_ready(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL drain_fetch_latency: got %0d expected 4", cyc); end
    endtask

    task automatic test_priority();
        stall = 6'b000001;
        ex_b_flag = 1'b1; ex_b_target = 32'h100;
        id_b_flag = 1'b1; id_b_target = 32'h200;
        tick();
        ex_b_flag = 1'b0; id_b_flag = 1'b0;
        n_cmp += 2;
        if (mem_addr !== 32'h100) begin n_err++; $display("FAIL prio_addr: got %h expected 00000100", mem_addr); end
        if (if_inst !== 32'h0)    begin n_err++; $display("FAIL prio_drop: got %h expected 0", if_inst); end
    endtask

    task automatic test_drain_overwrite();
        id_b_flag = 1'b1; id_b_target = 32'h80;
        tick();
        id_b_flag = 1'b0;
        tick();
        ex_b_flag = 1'b1; ex_b_target = 32'h90;
        tick();
        ex_b_flag = 1'b0;
        n_cmp++;
        if (mem_addr !== 32'h100) begin n_err++; $display("FAIL ovr_hold: got %h expected 00000100", mem_addr); end
        exp_addr_q.push_back(32'h100);
        mem_ack = 1'b1;
        tick();
        n_cmp++;
        if (mem_addr !== 32'h90) begin n_err++; $display("FAIL ovr_target: got %h expected 00000090", mem_addr); end
        exp_addr_q.push_back(32'h90);
    endtask

    task automatic test_redirect_ack();
        int cyc;
        id_b_flag = 1'b1; id_b_target = 32'h123;
        tick();
        id_b_flag = 1'b0;
        push_fetch(32'h123);
        n_cmp += 2;
        if (mem_addr !== 32'h123) begin n_err++; $display("FAIL rack_addr: got %h expected 00000123", mem_addr); end
        if (mem_req !== 1'b1)     begin n_err++; $display("FAIL rack_req: got %b expected 1", mem_req); end
        run_until_ready(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL unaligned_latency: got %0d expected 4", cyc); end
    endtask

    task automatic test_wrap();
        int cyc;
        push_fetch(32'hFFFF_FFFE);
        ex_b_flag = 1'b1; ex_b_target = 32'hFFFF_FFFE;
        tick();
        ex_b_flag = 1'b0;
        run_until_ready(cyc);
        n_cmp++;
        if (cyc !== 4) begin n_err++; $display("FAIL wrap_latency: got %0d expected 4", cyc); end
    endtask

    task automatic test_async_reset();
        int cyc;
        stall = 6'b000000;
        exp_addr_q.push_back(32'h2);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        n_cmp++;
        if (mem_addr !== 32'h3) begin n_err++; $display("FAIL pre_reset_addr: got %h expected 00000003", mem_addr); end
        #2 rst = 1'b0;
        #1;
        n_cmp += 4;
        if (mem_req !== 1'b0)     begin n_err++; $display("FAIL async_req: got %b expected 0", mem_req); end
        if (if_inst !== 32'h0)    begin n_err++; $display("FAIL async_inst: got %h expected 0", if_inst); end
        if (stallreq_if !== 1'b1) begin n_err++; $display("FAIL async_stallreq: got %b expected 1", stallreq_if); end
        if (mem_addr !== 32'h0)   begin n_err++; $display("FAIL async_addr: got %h expected 0", mem_addr); end
        tick();
        rst = 1'b1;
        push_fetch(32'h0);
        run_until_ready(cyc);
        n_cmp++;
        if (cyc !== 5) begin n_err++; $display("FAIL restart_latency: got %0d expected 5", cyc); end
    endtask

    initial begin
        stall = 6'b0; ex_b_flag = 1'b0; ex_b_target = 32'h0;
        id_b_flag = 1'b0; id_b_target = 32'h0;
        mem_ack = 1'b0; mem_rdata = 8'h0; rst = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = 8'((i * 37 + 11) & 8'hFF);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h50; mem[3] = 8'h00;

        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_drain_ex();
        test_priority();
        test_drain_overwrite();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        tick();

        n_cmp++;
        if (exp_addr_q.size() != 0 || exp_inst_q.size() != 0) begin
            n_err++;
            $display("FAIL leftover: got %0d addr %0d inst pending expected 0", exp_addr_q.size(), exp_inst_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is asynchronous and active-low (asserted when 0).
REQ-004 SHALL have port stall, input, 6, pipeline stall vector; bit 0 holds the fetch stage.
REQ-005 SHALL have port ex_b_flag, input, 1, branch/jump redirect from EX.
REQ-006 SHALL have port ex_b_target, input, 32, EX redirect address.
REQ-007 SHALL have port id_b_flag, input, 1, redirect from ID.
REQ-008 SHALL have port id_b_target, input, 32, ID redirect address.
REQ-009 SHALL have port mem_req, output, 1, byte read request.
REQ-010 SHALL have port mem_addr, output, 32, byte address.
REQ-011 SHALL have port mem_ack, input, 1, request accepted; mem_rdata is valid in the same cycle.
REQ-012 SHALL have port mem_rdata, input, 8, read byte.
REQ-013 SHALL have port if_pc, output, 32, PC of the presented instruction, which feeds the IF/ID register.
REQ-014 SHALL have port if_inst, output, 32, presented instruction; zero when none is presented.
REQ-015 SHALL have port stallreq_if, output, 1, request to the stall controller while no instruction is ready.

Function
REQ-016 SHALL implement states IDLE, FETCH, DRAIN and READY, with a 2-bit byte counter cnt and a 32-bit byte buffer.
REQ-017 SHALL leave IDLE for FETCH with cnt=0 on the first clock after reset release.
REQ-018 SHALL, in FETCH, drive mem_req=1 and mem_addr=pc+cnt (mod 2^32); on mem_ack it SHALL store mem_rdata in buffer[8*cnt+7:8*cnt] (little-endian) and increment cnt.
REQ-019 SHALL move from FETCH to READY on the mem_ack with cnt=3; a full fetch SHALL take at least 4 cycles.
REQ-020 SHALL, in READY, drive if_pc=pc, if_inst=buffer, mem_req=0 and stallreq_if=0.
REQ-021 SHALL drive if_pc=0, if_inst=0 and stallreq_if=1 in IDLE, FETCH and DRAIN.
REQ-022 SHALL, in READY with stall[0]=0, set pc<=pc+4 and move to FETCH with cnt=0; with stall[0]=1 it SHALL hold state and outputs.
REQ-023 SHALL hold mem_req and mem_addr stable once asserted until mem_ack is received (protocol rule).
REQ-024 SHALL give ex_b_flag priority over id_b_flag when both are asserted in the same cycle; the selected target is "tgt".
REQ-025 SHALL, on a redirect in READY, set pc<=tgt and enter FETCH with cnt=0, regardless of stall[0]; the current instruction is dropped.
REQ-026 SHALL, on a redirect in FETCH with mem_ack=1, discard that byte, set pc<=tgt and enter FETCH with cnt=0.
REQ-027 SHALL, on a redirect in FETCH with mem_ack=0, latch tgt and enter DRAIN while keeping mem_req and mem_addr unchanged.
REQ-028 SHALL, in DRAIN, overwrite the latched target on any new redirect (same priority as REQ-024); on mem_ack it SHALL discard the byte, set pc to the latched target and enter FETCH with cnt=0.
REQ-029 SHALL ignore stall while in FETCH and DRAIN, since fetch progress is independent of downstream stall.
REQ-030 SHALL fetch a target whose bits [1:0] are nonzero byte-wise as given, without raising an exception.

Reset
REQ-031 SHALL, on rst=0, immediately set state=IDLE, pc=RESET_PC, cnt=0, buffer=0, latched target=0, mem_req=0, mem_addr=0, if_pc=0, if_inst=0 and stallreq_if=1.
REQ-032 SHALL abandon any transaction in progress when reset is asserted mid-fetch; the memory side is reset by the same signal.

Structure
REQ-033 SHALL take ZeroWord, the InstAddrBus and InstBus widths, and the state encodings from the shared Defines header.
REQ-034 SHALL be a single module with no sub-modules; its output feeds the IF/ID register directly.

Verification
REQ-035 SHALL cover reset, then mem_ack=1 every cycle with bytes 13,00,50,00 -> mem_addr 0,1,2,3; READY on cycle 5 with if_inst=32'h0050_0013, if_pc=0.
REQ-036 SHALL cover READY with stall[0]=1 held 3 cycles -> outputs stable, mem_req=0; on release, next mem_addr=4.
REQ-037 SHALL cover, at the cnt=2 fetch of pc=8 with mem_ack=0, ex_b_flag=1 and ex_b_target=0x40 -> DRAIN holding addr 0xA; after the ack, fetch from 0x40,0x41,...
REQ-038 SHALL cover ex_b_flag (0x100) and id_b_flag (0x200) asserted together in READY -> next mem_addr=0x100.
REQ-039 SHALL cover, in DRAIN, id redirect 0x80 then ex redirect 0x90 on a later cycle -> after the ack, fetch starts at 0x90.
REQ-040 SHALL cover rst=0 asserted mid-FETCH with no clock edge -> mem_req=0 and if_inst=0 immediately; after release, fetch restarts at RESET_PC.
